// File: rtl/csr_arb_pkg.sv
// csr_arb_pkg: shared types and constants for the CSR write-port arbiter.
//   state_t : arbiter state (IDLE, BURST)
//   beat_t  : one CSR write {addr[11:0], data[31:0]}
//   CSR_*   : machine-mode CSR addresses used by trap bursts
package csr_arb_pkg;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } beat_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

endpackage

// File: rtl/csr_wb_fifo.sv
// csr_wb_fifo: synchronous FIFO of CSR write beats with async active-high reset.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (clears pointers/count)
//   push, wdata   : enqueue wdata when push && (!full || pop)
//   pop, rdata    : dequeue head when pop && !empty; rdata shows current head
//   full, empty   : occupancy flags
// DEPTH must be a power of two >= 2; pointers wrap naturally.
module csr_wb_fifo
  import csr_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  beat_t wdata,
  output beat_t rdata,
  output logic  full,
  output logic  empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  beat_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/csr_wport_arbiter.sv
// csr_wport_arbiter: shares the CSR file write port between the trap sequencer
// (multi-beat bursts) and WB-stage CSR instruction writes, preserving order.
// Ports:
//   clk, rst                          : clock, async active-high reset
//   trap_valid_i/addr_i/data_i/last_i : trap beat; trap_ready_o handshake
//   wb_valid_i/addr_i/data_i          : WB CSR write; wb_ready_o handshake
//   csr_we_o/waddr_o/wdata_o          : registered CSR file write port
//   burst_active_o                    : trap burst owns the port
//   pending_o                         : a write is queued or in flight (read stall)
// Optional feature: define CSR_WB_BUFFER_EN to buffer WB writes during a burst
// in a WB_FIFO_DEPTH-entry FIFO; otherwise WB stalls for the whole burst.
module csr_wport_arbiter
  import csr_arb_pkg::*;
#(
  parameter int unsigned WB_FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_valid_i,
  input  logic [11:0] trap_addr_i,
  input  logic [31:0] trap_data_i,
  input  logic        trap_last_i,
  output logic        trap_ready_o,
  input  logic        wb_valid_i,
  input  logic [11:0] wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic        wb_ready_o,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        burst_active_o,
  output logic        pending_o
);

  if (WB_FIFO_DEPTH < 2 || (WB_FIFO_DEPTH & (WB_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("WB_FIFO_DEPTH must be a power of two >= 2");
  end

  state_t state;
  logic   in_idle;
  logic   trap_fire;
  logic   wb_direct;
  logic   fifo_pop;
  logic   fifo_empty;
  logic   issue;
  beat_t  issue_beat;

  assign in_idle        = (state == IDLE);
  assign trap_fire      = trap_valid_i && trap_ready_o;
  assign burst_active_o = (state == BURST);

`ifdef CSR_WB_BUFFER_EN
  logic  fifo_full;
  logic  fifo_push;
  beat_t fifo_head;

  // WB goes straight to the port only when nothing is queued ahead of it;
  // otherwise it queues behind the head, which keeps acceptance order.
  assign wb_ready_o   = (in_idle && fifo_empty) ? 1'b1 : !fifo_full;
  assign trap_ready_o = !in_idle || (fifo_empty && !wb_valid_i);
  assign wb_direct    = in_idle && fifo_empty && wb_valid_i;
  assign fifo_pop     = in_idle && !fifo_empty;
  assign fifo_push    = wb_valid_i && wb_ready_o && !wb_direct;
  assign pending_o    = !fifo_empty || burst_active_o || csr_we_o;

  csr_wb_fifo #(
    .DEPTH (WB_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ('{addr: wb_addr_i, data: wb_data_i}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
`else
  assign fifo_empty   = 1'b1;
  assign fifo_pop     = 1'b0;
  assign wb_ready_o   = in_idle;
  assign trap_ready_o = !in_idle || !wb_valid_i;
  assign wb_direct    = in_idle && wb_valid_i;
  assign pending_o    = burst_active_o || csr_we_o;
`endif

  // The readies make these sources mutually exclusive; the ordering here
  // simply mirrors the priority FIFO head > WB direct > trap beat.
  always_comb begin
    issue      = 1'b0;
    issue_beat = '0;
`ifdef CSR_WB_BUFFER_EN
    if (fifo_pop) begin
      issue      = 1'b1;
      issue_beat = fifo_head;
    end else
`endif
    if (wb_direct) begin
      issue      = 1'b1;
      issue_beat = '{addr: wb_addr_i, data: wb_data_i};
    end else if (trap_fire) begin
      issue      = 1'b1;
      issue_beat = '{addr: trap_addr_i, data: trap_data_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      csr_we_o    <= 1'b0;
      csr_waddr_o <= '0;
      csr_wdata_o <= '0;
    end else begin
      if (trap_fire) state <= trap_last_i ? IDLE : BURST;
      csr_we_o <= issue;
      if (issue) begin
        csr_waddr_o <= issue_beat.addr;
        csr_wdata_o <= issue_beat.data;
      end
    end
  end

endmodule

// File: tb/tb_csr_wport_arbiter.sv
module tb_csr_wport_arbiter;
  import csr_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_valid_i, trap_last_i;
  logic [11:0] trap_addr_i, wb_addr_i;
  logic [31:0] trap_data_i, wb_data_i;
  logic        wb_valid_i;
  logic        trap_ready_o, wb_ready_o, csr_we_o, burst_active_o, pending_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  csr_wport_arbiter #(.WB_FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .trap_valid_i(trap_valid_i), .trap_addr_i(trap_addr_i),
    .trap_data_i(trap_data_i), .trap_last_i(trap_last_i),
    .trap_ready_o(trap_ready_o),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .wb_ready_o(wb_ready_o),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .burst_active_o(burst_active_o), .pending_o(pending_o)
  );

  task automatic chk(input string tag, input logic [43:0] obs, input logic [43:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write port check: we plus addr/data when a write is expected.
  task automatic chk_wr(input string tag, input logic we, input logic [11:0] a, input logic [31:0] d);
    chk({tag, ".we"}, 44'(csr_we_o), 44'(we));
    if (we) chk({tag, ".wr"}, {csr_waddr_o, csr_wdata_o}, {a, d});
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic trap(input logic v, input logic [11:0] a, input logic [31:0] d, input logic l);
    trap_valid_i = v; trap_addr_i = a; trap_data_i = d; trap_last_i = l;
  endtask

  task automatic wb(input logic v, input logic [11:0] a, input logic [31:0] d);
    wb_valid_i = v; wb_addr_i = a; wb_data_i = d;
  endtask

  initial begin
    rst = 1'b1;
    trap(0, '0, '0, 0);
    wb(0, '0, '0);
    #3;
    // Reset state
    chk("rst.we", 44'(csr_we_o), 44'd0);
    chk("rst.wr", {csr_waddr_o, csr_wdata_o}, 44'd0);
    chk("rst.burst", 44'(burst_active_o), 44'd0);
    chk("rst.pending", 44'(pending_o), 44'd0);
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("idle.trap_ready", 44'(trap_ready_o), 44'd1);
    chk("idle.wb_ready", 44'(wb_ready_o), 44'd1);

    // Single WB write
    wb(1, CSR_MSTATUS, 32'h0000_1888);
    #1;
    chk("wb1.wb_ready", 44'(wb_ready_o), 44'd1);
    chk("wb1.trap_ready", 44'(trap_ready_o), 44'd0);
    cyc();
    wb(0, '0, '0);
    chk_wr("wb1.out", 1, 12'h300, 32'h0000_1888);
    chk("wb1.pending", 44'(pending_o), 44'd1);
    cyc();
    chk_wr("wb1.after", 0, '0, '0);
    chk("wb1.pending_drop", 44'(pending_o), 44'd0);

    // Four-beat trap burst with a WB write arriving during beat 2
    trap(1, CSR_MEPC, 32'h8000_0010, 0);
    #1;
    chk("tb.b1_ready", 44'(trap_ready_o), 44'd1);
    cyc();
    chk_wr("tb.w1", 1, 12'h341, 32'h8000_0010);
    chk("tb.burst1", 44'(burst_active_o), 44'd1);
    trap(1, CSR_MCAUSE, 32'h0000_000B, 0);
    wb(1, 12'h305, 32'h8000_1000);
    #1;
`ifdef CSR_WB_BUFFER_EN
    chk("tb.wb_ready_b2", 44'(wb_ready_o), 44'd1);
`else
    chk("tb.wb_ready_b2", 44'(wb_ready_o), 44'd0);
`endif
    cyc();
`ifdef CSR_WB_BUFFER_EN
    wb(0, '0, '0);
`endif
    chk_wr("tb.w2", 1, 12'h342, 32'h0000_000B);
    chk("tb.pending", 44'(pending_o), 44'd1);
    trap(1, CSR_MTVAL, 32'h0, 0);
    cyc();
    chk_wr("tb.w3", 1, 12'h343, 32'h0);
    trap(1, CSR_MSTATUS, 32'h0000_1880, 1);
    #1;
    chk("tb.burst_b4", 44'(burst_active_o), 44'd1);
    chk("tb.b4_ready", 44'(trap_ready_o), 44'd1);
`ifndef CSR_WB_BUFFER_EN
    chk("tb.wb_ready_b4", 44'(wb_ready_o), 44'd0);
`endif
    cyc();
    trap(0, '0, '0, 0);
    chk_wr("tb.w4", 1, 12'h300, 32'h0000_1880);
    chk("tb.burst_end", 44'(burst_active_o), 44'd0);
    chk("tb.pending_after", 44'(pending_o), 44'd1);
    #1;
    chk("tb.trap_ready_after", 44'(trap_ready_o), 44'd0);
    cyc();
    wb(0, '0, '0);
    chk_wr("tb.wb_late", 1, 12'h305, 32'h8000_1000);
    cyc();
    chk_wr("tb.quiet", 0, '0, '0);
    chk("tb.pending_quiet", 44'(pending_o), 44'd0);

    // Simultaneous start: WB wins, single-beat trap follows, stays IDLE
    trap(1, CSR_MEPC, 32'h0000_0001, 1);
    wb(1, 12'h340, 32'h5);
    #1;
    chk("sim.trap_ready", 44'(trap_ready_o), 44'd0);
    chk("sim.wb_ready", 44'(wb_ready_o), 44'd1);
    cyc();
    wb(0, '0, '0);
    chk_wr("sim.wb_first", 1, 12'h340, 32'h5);
    #1;
    chk("sim.trap_ready2", 44'(trap_ready_o), 44'd1);
    cyc();
    trap(0, '0, '0, 0);
    chk_wr("sim.trap_second", 1, 12'h341, 32'h1);
    chk("sim.no_burst", 44'(burst_active_o), 44'd0);
    cyc();
    chk_wr("sim.quiet", 0, '0, '0);

    // Long burst with three WB writes against a 2-entry buffer
    trap(1, CSR_MEPC, 32'hA, 0);
    cyc();
    chk_wr("full.w1", 1, 12'h341, 32'hA);
    trap(1, CSR_MCAUSE, 32'hB, 0);
    wb(1, 12'h305, 32'h1);
    #1;
`ifdef CSR_WB_BUFFER_EN
    chk("full.rdy1", 44'(wb_ready_o), 44'd1);
`else
    chk("full.rdy1", 44'(wb_ready_o), 44'd0);
`endif
    cyc();
    chk_wr("full.w2", 1, 12'h342, 32'hB);
    trap(1, CSR_MTVAL, 32'hC, 0);
    wb(1, 12'h306, 32'h2);
    #1;
`ifdef CSR_WB_BUFFER_EN
    chk("full.rdy2", 44'(wb_ready_o), 44'd1);
`else
    chk("full.rdy2", 44'(wb_ready_o), 44'd0);
`endif
    cyc();
    chk_wr("full.w3", 1, 12'h343, 32'hC);
    trap(1, CSR_MIP, 32'hD, 0);
    wb(1, 12'h307, 32'h3);
    #1;
    chk("full.rdy3", 44'(wb_ready_o), 44'd0);
    cyc();
    chk_wr("full.w4", 1, 12'h344, 32'hD);
    trap(1, CSR_MSTATUS, 32'hE, 1);
    cyc();
    trap(0, '0, '0, 0);
    chk_wr("full.w5", 1, 12'h300, 32'hE);
    #1;
    chk("full.trap_ready_drain", 44'(trap_ready_o), 44'd0);
`ifdef CSR_WB_BUFFER_EN
    chk("full.rdy_full_idle", 44'(wb_ready_o), 44'd0);
    cyc();
    chk_wr("full.d1", 1, 12'h305, 32'h1);
    #1;
    chk("full.rdy_after_pop", 44'(wb_ready_o), 44'd1);
    cyc();
    wb(0, '0, '0);
    chk_wr("full.d2", 1, 12'h306, 32'h2);
    cyc();
    chk_wr("full.d3", 1, 12'h307, 32'h3);
`else
    chk("full.rdy_idle", 44'(wb_ready_o), 44'd1);
    cyc();
    wb(0, '0, '0);
    chk_wr("full.d1", 1, 12'h307, 32'h3);
`endif
    cyc();
    chk_wr("full.quiet", 0, '0, '0);
    chk("full.pending_quiet", 44'(pending_o), 44'd0);

    // Reset mid-burst with a buffered WB write
    trap(1, CSR_MEPC, 32'h11, 0);
    cyc();
    trap(1, CSR_MCAUSE, 32'h22, 0);
    wb(1, 12'h305, 32'h33);
    cyc();
    wb(0, '0, '0);
    trap(1, CSR_MTVAL, 32'h44, 0);
    chk_wr("rmb.w2", 1, 12'h342, 32'h22);
    chk("rmb.burst", 44'(burst_active_o), 44'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rmb.we", 44'(csr_we_o), 44'd0);
    chk("rmb.wr", {csr_waddr_o, csr_wdata_o}, 44'd0);
    chk("rmb.burst0", 44'(burst_active_o), 44'd0);
    chk("rmb.pending0", 44'(pending_o), 44'd0);
    trap(0, '0, '0, 0);
    cyc();
    rst = 1'b0;
    cyc();
    chk_wr("rmb.no_write1", 0, '0, '0);
    chk("rmb.pending1", 44'(pending_o), 44'd0);
    cyc();
    chk_wr("rmb.no_write2", 0, '0, '0);
    chk("rmb.wb_ready", 44'(wb_ready_o), 44'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
